fwd_hazard_ctrl: RTL and testbench

- Control-side counterpart of the 32-bit 4:1 forwarding operand muxes in the EX stage of the RV32I 5-stage pipeline.
- Tracks destination-register metadata for the EX, MEM and WB stages internally.
- Generates the 2-bit mux selects for ALU operands A and B.
- Detects load-use hazards (1-cycle stall) and applies branch/jump flushes.
- Keeps a saturating stall/flush performance counter.

---
 rtl/fwd_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Control side of the EX-stage operand forwarding muxes for a 5-stage RV32I
//   pipeline. Keeps destination-register metadata for the EX, MEM and WB
//   stages, produces the 2-bit forwarding selects for ALU operands A and B,
//   detects load-use hazards (one-cycle stall), applies branch/jump flushes
//   and counts stall/flush cycles in a saturating counter.
//
// Ports
//   clk          pipeline clock, rising edge
//   rst          asynchronous active-high reset
//   id_rs1/rs2   source registers of the instruction in ID
//   id_rd        destination register of the instruction in ID
//   id_use_rs1/2 ID instruction actually reads rs1 / rs2
//   id_regwrite  ID instruction writes rd
//   id_memread   ID instruction is a load
//   ex_br_taken  branch/jump resolved taken in EX this cycle
//   pc_we        PC write enable
//   ifid_we      IF/ID register write enable
//   ifid_flush   clear IF/ID to NOP
//   idex_flush   clear ID/EX to NOP
//   fwd_a/fwd_b  operand mux selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   hz_cnt       saturating count of cycles with stall or flush
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic [RADDR-1:0] id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_br_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [XLEN-1:0]  hz_cnt
);

    typedef struct packed {
        logic             valid;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
        logic [RADDR-1:0] rd;
        logic             regwrite;
        logic             memread;
    } stage_rec_t;

    localparam logic [RADDR-1:0] REG_X0   = {RADDR{1'b0}};
    localparam logic [XLEN-1:0]  CNT_MAX  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  CNT_ONE  = {{(XLEN-1){1'b0}}, 1'b1};

    stage_rec_t ex_r;
    stage_rec_t mem_r;
    stage_rec_t wb_r;
    stage_rec_t id_rec_s;
    logic       stall_s;
    logic       hz_event_s;
    logic       unused_rec_bits_s;

    // Forwarding select for one operand: MEM beats WB, x0 is never forwarded,
    // and an invalid EX record or an unread source always takes the regfile.
    function automatic logic [1:0] fwd_sel(
        input logic             ex_valid,
        input logic             use_src,
        input logic [RADDR-1:0] src,
        input stage_rec_t       mem_rec,
        input stage_rec_t       wb_rec
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (!ex_valid || !use_src) begin
            sel = 2'b00;
        end else if (mem_rec.valid && mem_rec.regwrite &&
                     (mem_rec.rd != REG_X0) && (mem_rec.rd == src)) begin
            sel = 2'b01;
        end else if (wb_rec.valid && wb_rec.regwrite &&
                     (wb_rec.rd != REG_X0) && (wb_rec.rd == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Pack the ID-stage fields into the record that enters EX next edge.
    always_comb begin
        id_rec_s          = '0;
        id_rec_s.valid    = 1'b1;
        id_rec_s.rs1      = id_rs1;
        id_rec_s.rs2      = id_rs2;
        id_rec_s.use_rs1  = id_use_rs1;
        id_rec_s.use_rs2  = id_use_rs2;
        id_rec_s.rd       = id_rd;
        id_rec_s.regwrite = id_regwrite;
        id_rec_s.memread  = id_memread;
    end

    // Load-use detection: a load in EX whose rd is read by the ID instruction.
    always_comb begin
        stall_s = ex_r.valid && ex_r.memread && (ex_r.rd != REG_X0) &&
                  ((id_use_rs1 && (id_rs1 == ex_r.rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_r.rd)));
    end

    // Pipeline control; a taken branch overrides the stall, and reset forces
    // the idle values even if the branch input is still asserted.
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end else if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall_s) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
        end
    end

    // Operand forwarding selects derived from the EX record.
    always_comb begin
        fwd_a = fwd_sel(ex_r.valid, ex_r.use_rs1, ex_r.rs1, mem_r, wb_r);
        fwd_b = fwd_sel(ex_r.valid, ex_r.use_rs2, ex_r.rs2, mem_r, wb_r);
    end

    // Cycles counted by the performance counter.
    always_comb begin
        hz_event_s = !rst && (stall_s || ex_br_taken);
    end

    // WB and some record fields are carried to keep the records uniform even
    // though the selects do not consume every bit.
    assign unused_rec_bits_s = ^{wb_r, mem_r, ex_r.regwrite};

    // Stage record advance; a flushed ID/EX becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            if (idex_flush) begin
                ex_r <= '0;
            end else begin
                ex_r <= id_rec_s;
            end
        end
    end

    // Saturating stall/flush counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hz_cnt <= '0;
        end else if (hz_event_s && (hz_cnt != CNT_MAX)) begin
            hz_cnt <= hz_cnt + CNT_ONE;
        end else begin
            hz_cnt <= hz_cnt;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//   Directed bench for fwd_hazard_ctrl. Inputs change 1 time unit after the
//   rising edge and outputs are checked 1 time unit later, away from the edge.
//   A second instance with a 2-bit counter exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_regwrite;
    logic       id_memread;
    logic       ex_br_taken;

    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] hz_cnt;

    logic        sat_pc_we;
    logic        sat_ifid_we;
    logic        sat_ifid_flush;
    logic        sat_idex_flush;
    logic [1:0]  sat_fwd_a;
    logic [1:0]  sat_fwd_b;
    logic [1:0]  sat_hz_cnt;

    int checks;
    int failures;

    fwd_hazard_ctrl #(.XLEN(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_br_taken(ex_br_taken),
        .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .hz_cnt(hz_cnt)
    );

    fwd_hazard_ctrl #(.XLEN(2), .RADDR(5)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_br_taken(ex_br_taken),
        .pc_we(sat_pc_we), .ifid_we(sat_ifid_we),
        .ifid_flush(sat_ifid_flush), .idex_flush(sat_idex_flush),
        .fwd_a(sat_fwd_a), .fwd_b(sat_fwd_b), .hz_cnt(sat_hz_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic rw, input logic mr);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic nop_id();
        set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pc_we, ifid_we, ifid_flush, idex_flush packed as a 4-bit word.
    function automatic logic [31:0] ctl();
        return {28'd0, pc_we, ifid_we, ifid_flush, idex_flush};
    endfunction

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        ex_br_taken = 1'b0;
        nop_id();

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl_during", ctl(), 32'hC);
        check("rst_fwd_during", {28'd0, fwd_a, fwd_b}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_ctl_after", ctl(), 32'hC);
        check("rst_fwd_after", {28'd0, fwd_a, fwd_b}, 32'h0);
        check("rst_hz_cnt", hz_cnt, 32'd0);
        tick();

        // EX->EX forward: add x5,x1,x2 ; sub x6,x5,x7
        set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("exex_no_stall", ctl(), 32'hC);
        tick();
        nop_id();
        #1;
        check("exex_fwd_a", {30'd0, fwd_a}, 32'd1);
        check("exex_fwd_b", {30'd0, fwd_b}, 32'd0);

        // Same with x0 as destination: add x0,x1,x2 ; sub x6,x0,x7
        set_id(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd0, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        nop_id();
        #1;
        check("x0_fwd_a", {30'd0, fwd_a}, 32'd0);

        // Double match: add x5 ; add x5 ; or x8,x5,x5 -> MEM wins
        set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        set_id(5'd5, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        nop_id();
        #1;
        check("dbl_mem_fwd_a", {30'd0, fwd_a}, 32'd1);
        check("dbl_mem_fwd_b", {30'd0, fwd_b}, 32'd1);

        // add x5 ; add x5 ; nop ; or x8,x5,x5 -> WB forward
        set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        nop_id();
        tick();
        set_id(5'd5, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        nop_id();
        #1;
        check("dbl_wb_fwd_a", {30'd0, fwd_a}, 32'd2);
        check("dbl_wb_fwd_b", {30'd0, fwd_b}, 32'd2);
        check("pre_lu_hz_cnt", hz_cnt, 32'd0);

        // Load-use: lw x3,0(x2) ; add x4,x3,x1
        set_id(5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("lu_stall_ctl", ctl(), 32'h1);
        check("lu_stall_hz_cnt", hz_cnt, 32'd0);
        tick();
        check("lu_release_ctl", ctl(), 32'hC);
        check("lu_bubble_fwd", {28'd0, fwd_a, fwd_b}, 32'h0);
        check("lu_hz_cnt_1", hz_cnt, 32'd1);
        tick();
        nop_id();
        #1;
        check("lu_fwd_a", {30'd0, fwd_a}, 32'd2);
        check("lu_fwd_b", {30'd0, fwd_b}, 32'd0);
        check("lu_hz_cnt_hold", hz_cnt, 32'd1);

        // Branch and load-use in the same cycle: branch wins
        set_id(5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        ex_br_taken = 1'b1;
        #1;
        check("br_stall_ctl", ctl(), 32'hF);
        tick();
        ex_br_taken = 1'b0;
        nop_id();
        #1;
        check("br_stall_hz_cnt", hz_cnt, 32'd2);
        check("br_after_ctl", ctl(), 32'hC);

        // Reset asserted during a stall cycle
        set_id(5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("mid_stall_ctl", ctl(), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_ctl", ctl(), 32'hC);
        check("mid_rst_hz_cnt", hz_cnt, 32'd0);
        ex_br_taken = 1'b1;
        #1;
        check("mid_rst_br_ctl", ctl(), 32'hC);
        ex_br_taken = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ctl", ctl(), 32'hC);
        check("post_rst_fwd", {28'd0, fwd_a, fwd_b}, 32'h0);
        tick();
        nop_id();
        #1;
        check("post_rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        check("post_rst_hz_cnt", hz_cnt, 32'd0);

        // Counter saturation on the 2-bit instance
        ex_br_taken = 1'b1;
        repeat (3) tick();
        check("sat_hz_cnt_3", {30'd0, sat_hz_cnt}, 32'd3);
        check("main_hz_cnt_3", hz_cnt, 32'd3);
        repeat (2) tick();
        ex_br_taken = 1'b0;
        #1;
        check("sat_hz_cnt_hold", {30'd0, sat_hz_cnt}, 32'd3);
        check("main_hz_cnt_5", hz_cnt, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
